rf_wb_sched: RTL

- Write-back and free scheduler in front of the bypass register file.
- Shares the RF's two write-data ports among NUM_REQ write-back requesters using round-robin arbitration, with one registered issue stage.
- Accepts out-of-order "free name" requests and retires them to the RF strictly in name order, because the RF only frees the oldest owner.
- Sits between the pipeline write-back stages and the RF's NAME_IN/D_IN/WE and W_F/WFE/F_READY ports.

---
 rtl/rf_wb_sched_pkg.sv | 25 ++
 rtl/rf_wb_sched_if.sv | 51 +++++
 rtl/rf_wb_sched_rr_pick2.sv | 63 ++++++
 rtl/rf_wb_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_sched_pkg.sv
// ---------------------------------------------------------------------------
// rf_sched_pkg
// Shared definitions for the RF write-back / free scheduler slice.
//   - Default widths and requester count used by the scheduler, its
//     interface and its sub-modules.
//   - rrNext  : round-robin successor of an index, wrapping at n.
//   - nameInc : wrap-around increment of an RF name, wrapping at numNames.
// ---------------------------------------------------------------------------
package rf_sched_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_NAME_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 32;

  // Next requester index in round-robin order.
  function automatic int rrNext(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Next RF name; names wrap to zero after the last one.
  function automatic int nameInc(input int name, input int numNames);
    return (name + 1 >= numNames) ? 0 : name + 1;
  endfunction

endpackage

// File: rtl/rf_wb_sched_if.sv
// ---------------------------------------------------------------------------
// rf_wb_sched_if
// Bundles every non-clock/reset signal of the write-back scheduler.
//   Requester side : REQ_VALID, REQ_NAME, REQ_DATA (in), REQ_READY (out)
//   RF write ports : NAME_IN_1/2, D_IN_1/2, WE_1/2 (out)
//   Free intake    : FREE_VALID, FREE_NAME (in), FREE_READY (out)
//   RF free port   : W_F, WFE (out), F_READY (in)
// Modport slave is the scheduler's view, master is the surrounding
// pipeline/RF view.
// ---------------------------------------------------------------------------
interface rf_wb_sched_if
  import rf_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int name_width = DEF_NAME_WIDTH,
  parameter int data_width = DEF_DATA_WIDTH
);

  logic [NUM_REQ-1:0]            REQ_VALID;
  logic [NUM_REQ*name_width-1:0] REQ_NAME;
  logic [NUM_REQ*data_width-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            REQ_READY;

  logic [name_width-1:0]         NAME_IN_1;
  logic [data_width-1:0]         D_IN_1;
  logic                          WE_1;
  logic [name_width-1:0]         NAME_IN_2;
  logic [data_width-1:0]         D_IN_2;
  logic                          WE_2;

  logic                          FREE_VALID;
  logic [name_width-1:0]         FREE_NAME;
  logic                          FREE_READY;

  logic [name_width-1:0]         W_F;
  logic                          WFE;
  logic                          F_READY;

  modport slave (
    input  REQ_VALID, REQ_NAME, REQ_DATA, FREE_VALID, FREE_NAME, F_READY,
    output REQ_READY, NAME_IN_1, D_IN_1, WE_1, NAME_IN_2, D_IN_2, WE_2,
           FREE_READY, W_F, WFE
  );

  modport master (
    output REQ_VALID, REQ_NAME, REQ_DATA, FREE_VALID, FREE_NAME, F_READY,
    input  REQ_READY, NAME_IN_1, D_IN_1, WE_1, NAME_IN_2, D_IN_2, WE_2,
           FREE_READY, W_F, WFE
  );

endinterface

// File: rtl/rf_wb_sched_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-grant round-robin picker.
//   i_valid   : request vector
//   i_ptr     : index where the scan starts
//   o_grant1  : one-hot grant of the first valid requester found
//   o_grant2  : one-hot grant of the second valid requester found
//   o_nextPtr : one past the last granted index, or i_ptr when idle
// ---------------------------------------------------------------------------
module rr_pick2
  import rf_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant1,
  output logic [NUM_REQ-1:0] o_grant2,
  output logic [PTR_W-1:0]   o_nextPtr
);

  int               w_scan;
  logic [PTR_W-1:0] w_idx1;
  logic [PTR_W-1:0] w_idx2;
  logic             w_found1;
  logic             w_found2;

  // Walk all requesters once starting at the pointer; the first two valid
  // ones win. The pointer then moves just past the last winner so the
  // losers are scanned first next time.
  always_comb begin
    o_grant1  = '0;
    o_grant2  = '0;
    w_idx1    = '0;
    w_idx2    = '0;
    w_found1  = 1'b0;
    w_found2  = 1'b0;
    w_scan    = int'(i_ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_valid[PTR_W'(w_scan)]) begin
        if (!w_found1) begin
          w_found1                  = 1'b1;
          w_idx1                    = PTR_W'(w_scan);
          o_grant1[PTR_W'(w_scan)]  = 1'b1;
        end else if (!w_found2) begin
          w_found2                  = 1'b1;
          w_idx2                    = PTR_W'(w_scan);
          o_grant2[PTR_W'(w_scan)]  = 1'b1;
        end
      end
      w_scan = rrNext(w_scan, NUM_REQ);
    end
    if (w_found2) begin
      o_nextPtr = PTR_W'(rrNext(int'(w_idx2), NUM_REQ));
    end else if (w_found1) begin
      o_nextPtr = PTR_W'(rrNext(int'(w_idx1), NUM_REQ));
    end else begin
      o_nextPtr = i_ptr;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// ---------------------------------------------------------------------------
// rf_wb_sched
// Write-back and free scheduler in front of the bypass register file.
//   - Shares the RF's two write ports among NUM_REQ requesters with a
//     two-grant round-robin arbiter and one registered issue stage.
//   - Collects out-of-order free requests in a pending bitmap and retires
//     them to the RF strictly in name order.
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   bus      : rf_wb_sched_if.slave (requester bus, RF write ports,
//              free intake, RF free port)
// Optional build macro RF_WB_SCHED_CHECK_EN adds simulation-only checks
// (duplicate granted names, stuck free request, stalled RF free).
// ---------------------------------------------------------------------------
module rf_wb_sched
  import rf_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int name_width = DEF_NAME_WIDTH,
  parameter int data_width = DEF_DATA_WIDTH
) (
  input logic          CLK,
  input logic          RST,
  rf_wb_sched_if.slave bus
);

  localparam int PTR_W     = $clog2(NUM_REQ);
  localparam int NUM_NAMES = 2 ** name_width;

  logic [PTR_W-1:0]      r_rrPtr;
  logic [NUM_REQ-1:0]    w_valid;
  logic [NUM_REQ-1:0]    w_grant1;
  logic [NUM_REQ-1:0]    w_grant2;
  logic [PTR_W-1:0]      w_nextPtr;
  logic                  w_any1;
  logic                  w_any2;
  logic [name_width-1:0] w_name1;
  logic [name_width-1:0] w_name2;
  logic [data_width-1:0] w_data1;
  logic [data_width-1:0] w_data2;

  logic                  r_we1;
  logic                  r_we2;
  logic [name_width-1:0] r_name1;
  logic [name_width-1:0] r_name2;
  logic [data_width-1:0] r_data1;
  logic [data_width-1:0] r_data2;

  logic [NUM_NAMES-1:0]  r_pending;
  logic [name_width-1:0] r_freePtr;
  logic                  w_freeReady;
  logic                  w_intake;
  logic                  w_hazard;
  logic                  w_wfe;
  logic                  w_retire;

  // Requests are masked during reset so no transfer is acknowledged while
  // the issue stage is being cleared.
  assign w_valid = RST ? '0 : bus.REQ_VALID;

  rr_pick2 #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_valid   (w_valid),
    .i_ptr     (r_rrPtr),
    .o_grant1  (w_grant1),
    .o_grant2  (w_grant2),
    .o_nextPtr (w_nextPtr)
  );

  assign w_any1 = |w_grant1;
  assign w_any2 = |w_grant2;

  // One-hot mux of the granted requesters' name and data onto the two slots.
  always_comb begin
    w_name1 = '0;
    w_name2 = '0;
    w_data1 = '0;
    w_data2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant1[i]) begin
        w_name1 = bus.REQ_NAME[i*name_width +: name_width];
        w_data1 = bus.REQ_DATA[i*data_width +: data_width];
      end
      if (w_grant2[i]) begin
        w_name2 = bus.REQ_NAME[i*name_width +: name_width];
        w_data2 = bus.REQ_DATA[i*data_width +: data_width];
      end
    end
  end

  // Issue stage: slot 1 always feeds port 1, so a lone grant lands there.
  // Name/data only reload on a grant and otherwise hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rrPtr <= '0;
      r_we1   <= 1'b0;
      r_we2   <= 1'b0;
      r_name1 <= '0;
      r_name2 <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
    end else begin
      r_rrPtr <= w_nextPtr;
      r_we1   <= w_any1;
      r_we2   <= w_any2;
      if (w_any1) begin
        r_name1 <= w_name1;
        r_data1 <= w_data1;
      end
      if (w_any2) begin
        r_name2 <= w_name2;
        r_data2 <= w_data2;
      end
    end
  end

  // A name may only be freed once no write to it is granted or staged,
  // otherwise the write would land in the RF after the owner was released.
  assign w_hazard = (r_we1  && (r_name1 == r_freePtr)) ||
                    (r_we2  && (r_name2 == r_freePtr)) ||
                    (w_any1 && (w_name1 == r_freePtr)) ||
                    (w_any2 && (w_name2 == r_freePtr));

  assign w_freeReady = !r_pending[bus.FREE_NAME];
  assign w_intake    = !RST && bus.FREE_VALID && w_freeReady;
  assign w_wfe       = !RST && r_pending[r_freePtr] && !w_hazard;
  assign w_retire    = w_wfe && bus.F_READY;

  // Intake and retire never touch the same bit in one cycle: retire needs
  // the bit already set while intake needs it clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pending <= '0;
      r_freePtr <= '0;
    end else begin
      if (w_retire) begin
        r_pending[r_freePtr] <= 1'b0;
        r_freePtr <= name_width'(nameInc(int'(r_freePtr), NUM_NAMES));
      end
      if (w_intake) begin
        r_pending[bus.FREE_NAME] <= 1'b1;
      end
    end
  end

  assign bus.REQ_READY  = w_grant1 | w_grant2;
  assign bus.NAME_IN_1  = r_name1;
  assign bus.D_IN_1     = r_data1;
  assign bus.WE_1       = r_we1;
  assign bus.NAME_IN_2  = r_name2;
  assign bus.D_IN_2     = r_data2;
  assign bus.WE_2       = r_we2;
  assign bus.FREE_READY = w_freeReady;
  assign bus.W_F        = r_freePtr;
  assign bus.WFE        = w_wfe;

`ifdef RF_WB_SCHED_CHECK_EN
  int r_stuckFreeCnt;
  int r_stallWfeCnt;

  // Simulation-only sanity checks on the surrounding pipeline and RF.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stuckFreeCnt <= 0;
      r_stallWfeCnt  <= 0;
    end else begin
      if (w_any2 && (w_name1 == w_name2)) begin
        $error("rf_wb_sched: duplicate name %0d granted in one cycle", w_name1);
      end
      if (bus.FREE_VALID && !w_freeReady) begin
        r_stuckFreeCnt <= r_stuckFreeCnt + 1;
        if (r_stuckFreeCnt >= 64) begin
          $error("rf_wb_sched: free of name %0d stuck behind pending bit", bus.FREE_NAME);
        end
      end else begin
        r_stuckFreeCnt <= 0;
      end
      if (w_wfe && !bus.F_READY) begin
        r_stallWfeCnt <= r_stallWfeCnt + 1;
        if (r_stallWfeCnt >= 64) begin
          $error("rf_wb_sched: RF free of name %0d not accepted", r_freePtr);
        end
      end else begin
        r_stallWfeCnt <= 0;
      end
    end
  end
`endif

endmodule
